// File: rtl/ir_queue_if.sv
// Fetch-to-decode instruction queue bus: the fetch side offers words with PCs,
// and the decode side takes the head entry already split into MIPS fields.
interface ir_queue_if #(
  parameter int WORD_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a beat transfers on a rising edge where valid && ready. Valid
  // never depends on ready. The queue's in_ready and out_valid come from
  // registers only. flush beats any transfer in the same cycle.
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_instr;
  logic [PC_WIDTH-1:0]   in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [5:0]            op;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [15:0]           imm16;
  logic [25:0]           addr26;
  logic [CW-1:0]         count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, op, rs, rt, rd, shamt,
           funct, imm16, addr26, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, op, rs, rt, rd, shamt,
           funct, imm16, addr26, count
  );
endinterface

// File: rtl/ir_queue.sv
// Instruction register queue between fetch and decode. It is a circular buffer
// that holds instructions with their PCs and presents the head already decoded into fields.
module ir_queue #(
  parameter int WORD_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4
) (
  input logic        CLK,
  input logic        RST_n,
  ir_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_r;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] head_instr;
  logic [PC_WIDTH-1:0]   head_pc;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign push  = q.in_valid & ~full;
  assign pop   = ~empty & q.out_ready;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST_n || q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is never reset. Only entries between rd_ptr and wr_ptr are visible.
  always_ff @(posedge CLK) begin
    if (RST_n && !q.flush && push) begin
      instr_mem[wr_ptr] <= q.in_instr;
      pc_mem[wr_ptr]    <= q.in_pc;
    end
  end

  // Mask the head when empty, so decode never sees a stale entry.
  assign head_instr = empty ? '0 : instr_mem[rd_ptr];
  assign head_pc    = empty ? '0 : pc_mem[rd_ptr];

  assign q.in_ready  = ~full;
  assign q.out_valid = ~empty;
  assign q.count     = count_r;
  assign q.out_instr = head_instr;
  assign q.out_pc    = head_pc;
  assign q.op        = head_instr[31:26];
  assign q.rs        = head_instr[25:21];
  assign q.rt        = head_instr[20:16];
  assign q.rd        = head_instr[15:11];
  assign q.shamt     = head_instr[10:6];
  assign q.funct     = head_instr[5:0];
  assign q.imm16     = head_instr[15:0];
  assign q.addr26    = head_instr[25:0];
endmodule
